// File: rtl/gate_event_pkg.sv
// Shared types and constants for the gate event capture block.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package gate_event_pkg;

  // Default width of the reported pulse-width field
  localparam int WIDTH_W_DEF = 16;

  // Number of cycles spent in INIT after reset release
  localparam int INIT_CYCLES = 2;

  typedef enum logic {
    INIT    = 1'b0,
    MEASURE = 1'b1
  } state_t;

endpackage

// File: rtl/gate_event_capture_sync_2ff.sv
// Two-flop synchronizer bringing an asynchronous level into the clk domain.
// Latency: 2 cycles from d to q.
// Backpressure: none; free-running.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic s1;

  // Metastability filter: s1 may go metastable, q sees a resolved value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      q  <= 1'b0;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/gate_event_capture.sv
// Measures how long a synchronized level stays stable and reports each transition as an event.
// Latency: evt_valid rises on the 3rd rising edge after sig_in changes.
// Backpressure: one-entry event register; transitions arriving while it is held are dropped and flagged.
module gate_event_capture
  import gate_event_pkg::*;
#(
  parameter int WIDTH_W = WIDTH_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               sig_in,
  input  logic               clear,
  input  logic               evt_ready,
  output logic               evt_valid,
  output logic               evt_level,
  output logic [WIDTH_W-1:0] evt_width,
  output logic [7:0]         evt_count,
  output logic               evt_overflow
);

  localparam logic [WIDTH_W-1:0] W_MAX     = '1;
  localparam logic [WIDTH_W-1:0] W_ONE     = {{(WIDTH_W-1){1'b0}}, 1'b1};
  localparam logic [1:0]         INIT_LAST = 2'(INIT_CYCLES - 1);

  state_t             state;
  state_t             state_nxt;
  logic [1:0]         init_cnt;
  logic [1:0]         init_cnt_nxt;
  logic               s2;
  logic               s3;
  logic [WIDTH_W-1:0] width_cnt;
  logic [WIDTH_W-1:0] width_cnt_nxt;
  logic [WIDTH_W-1:0] width_cap;
  logic               trans;
  logic               hs;

  sync_2ff u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (sig_in),
    .q     (s2)
  );

  // Previous synchronized level; tracks s2 in every state so INIT exits with s3 valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s3 <= 1'b0;
    end else begin
      s3 <= s2;
    end
  end

  // FSM state register plus the INIT dwell counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= INIT;
      init_cnt <= 2'd0;
    end else begin
      state    <= state_nxt;
      init_cnt <= init_cnt_nxt;
    end
  end

  // Next-state: INIT dwells a fixed number of cycles, MEASURE is terminal until reset
  always_comb begin
    state_nxt    = state;
    init_cnt_nxt = init_cnt;
    case (state)
      INIT: begin
        if (init_cnt == INIT_LAST) begin
          state_nxt    = MEASURE;
          init_cnt_nxt = 2'd0;
        end else begin
          init_cnt_nxt = init_cnt + 2'd1;
        end
      end
      MEASURE: state_nxt = MEASURE;
      default: state_nxt = INIT;
    endcase
  end

  // Edge detect, handshake and saturating width arithmetic
  always_comb begin
    trans     = (state == MEASURE) && (s2 != s3);
    hs        = evt_valid && evt_ready;
    width_cap = (width_cnt == W_MAX) ? W_MAX : (width_cnt + W_ONE);
    if ((state != MEASURE) || clear || trans) begin
      width_cnt_nxt = '0;
    end else begin
      width_cnt_nxt = width_cap;
    end
  end

  // Width counter: held at 0 in INIT, restarts on a transition or clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      width_cnt <= '0;
    end else begin
      width_cnt <= width_cnt_nxt;
    end
  end

  // Event register: clear wins, a handshake frees the slot for a same-cycle transition
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      evt_valid    <= 1'b0;
      evt_level    <= 1'b0;
      evt_width    <= '0;
      evt_count    <= 8'd0;
      evt_overflow <= 1'b0;
    end else if (clear) begin
      evt_valid    <= 1'b0;
      evt_count    <= 8'd0;
      evt_overflow <= 1'b0;
    end else begin
      if (hs) begin
        evt_count <= evt_count + 8'd1;
      end
      if (trans && (!evt_valid || hs)) begin
        evt_valid <= 1'b1;
        evt_level <= s3;
        evt_width <= width_cap;
      end else if (trans) begin
        evt_overflow <= 1'b1;
      end else if (hs) begin
        evt_valid <= 1'b0;
      end
    end
  end

endmodule
